cp0_exc_ctrl: RTL and testbench



---
 rtl/cp0_pkg.sv | 33 +++
 rtl/cp0_trap_decode.sv | 39 +++
 rtl/cp0_exc_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: cause codes, CP0 register indices, FSM encoding
// and the default exception vector.
package cp0_pkg;

  localparam logic [4:0] CAUSE_NONE    = 5'b00000;
  localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0040_0004;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_EXC_ISSUE  = 3'd1,
    ST_EXC_REDIR  = 3'd2,
    ST_ERET_ISSUE = 3'd3,
    ST_ERET_REDIR = 3'd4
  } cp0_state_e;

  // Winner of the decode priority encode for one instruction slot.
  typedef enum logic [2:0] {
    REQ_NONE = 3'd0,
    REQ_TRAP = 3'd1,
    REQ_ERET = 3'd2,
    REQ_MTC0 = 3'd3,
    REQ_MFC0 = 3'd4
  } cp0_req_e;

endpackage

// File: rtl/cp0_trap_decode.sv
// Priority encode of decoded instruction flags into a single CP0 request
// (syscall > break > taken teq > eret > mtc0 > mfc0) plus the trap cause.
module cp0_trap_decode
  import cp0_pkg::*;
(
  input  logic       is_syscall,
  input  logic       is_break,
  input  logic       is_teq,
  input  logic       teq_equal,
  input  logic       is_mfc0,
  input  logic       is_mtc0,
  input  logic       is_eret,
  output cp0_req_e   req,
  output logic [4:0] trap_cause
);

  always_comb begin
    req        = REQ_NONE;
    trap_cause = CAUSE_NONE;
    if (is_syscall) begin
      req        = REQ_TRAP;
      trap_cause = CAUSE_SYSCALL;
    end else if (is_break) begin
      req        = REQ_TRAP;
      trap_cause = CAUSE_BREAK;
    end else if (is_teq && teq_equal) begin
      // An untaken TEQ falls through, so a lower-priority flag may still win.
      req        = REQ_TRAP;
      trap_cause = CAUSE_TEQ;
    end else if (is_eret) begin
      req = REQ_ERET;
    end else if (is_mtc0) begin
      req = REQ_MTC0;
    end else if (is_mfc0) begin
      req = REQ_MFC0;
    end
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CPU-side CP0 initiator: sequences exception entry/return, drives CP0 strobes,
// the fetch redirect/stall, and tracks exception nesting depth.
// Strobe semantics: cp0_ena with one of mfc0/mtc0/eret or a non-zero cause is a
// one-cycle request CP0 samples on the negedge; there is no back-pressure.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
  parameter logic [31:0] ERET_OFFSET = 32'd4,
  parameter int          MAX_NEST    = 6
) (
  input  logic        cp0_clk,
  input  logic        cp0_rst,
  input  logic        ena,
  input  logic        is_syscall,
  input  logic        is_break,
  input  logic        is_teq,
  input  logic        teq_equal,
  input  logic        is_mfc0,
  input  logic        is_mtc0,
  input  logic        is_eret,
  input  logic [4:0]  rd,
  input  logic [31:0] pc_in,
  input  logic [31:0] epc_in,
  output logic        cp0_ena,
  output logic        mfc0,
  output logic        mtc0,
  output logic        eret,
  output logic [4:0]  cause,
  output logic [31:0] addr,
  output logic [31:0] pc_out,
  output logic        stall,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic [2:0]  nest_depth,
  output logic        nest_err,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] MAX_DEPTH = 3'(MAX_NEST);

  cp0_state_e  state, state_nxt;
  cp0_req_e    req;
  logic [4:0]  dec_cause;
  logic [4:0]  cause_q;
  logic [31:0] pc_q;
  logic [31:0] epc_q;
  logic [2:0]  depth_q;
  logic        err_q;
  logic        go;
  logic        take_trap;
  logic        err_set;

  cp0_trap_decode u_decode (
    .is_syscall (is_syscall),
    .is_break   (is_break),
    .is_teq     (is_teq),
    .teq_equal  (teq_equal),
    .is_mfc0    (is_mfc0),
    .is_mtc0    (is_mtc0),
    .is_eret    (is_eret),
    .req        (req),
    .trap_cause (dec_cause)
  );

  // Reset also gates the combinational IDLE path so nothing leaks while held.
  assign go = ena && !cp0_rst;

  always_ff @(posedge cp0_clk or posedge cp0_rst) begin
    if (cp0_rst) begin
      state   <= ST_IDLE;
      cause_q <= CAUSE_NONE;
      pc_q    <= '0;
      epc_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else if (ena) begin
      state <= state_nxt;
      if (take_trap) begin
        pc_q    <= pc_in;
        cause_q <= dec_cause;
      end
      if (err_set) err_q <= 1'b1;
      if (state == ST_EXC_ISSUE) depth_q <= depth_q + 3'd1;
      if (state == ST_ERET_ISSUE) begin
        epc_q   <= epc_in;
        depth_q <= depth_q - 3'd1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    take_trap   = 1'b0;
    err_set     = 1'b0;
    cp0_ena     = 1'b0;
    mfc0        = 1'b0;
    mtc0        = 1'b0;
    eret        = 1'b0;
    cause       = CAUSE_NONE;
    addr        = '0;
    stall       = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          case (req)
            REQ_TRAP: begin
              if (depth_q < MAX_DEPTH) begin
                take_trap = 1'b1;
                stall     = 1'b1;
                state_nxt = ST_EXC_ISSUE;
              end else begin
                err_set = 1'b1;
              end
            end
            REQ_ERET: begin
              if (depth_q != 3'd0) begin
                stall     = 1'b1;
                state_nxt = ST_ERET_ISSUE;
              end else begin
                err_set = 1'b1;
              end
            end
            REQ_MTC0: begin
              cp0_ena = 1'b1;
              mtc0    = 1'b1;
              addr    = {27'b0, rd};
            end
            REQ_MFC0: begin
              cp0_ena = 1'b1;
              mfc0    = 1'b1;
              addr    = {27'b0, rd};
            end
            default: ;
          endcase
        end
      end
      ST_EXC_ISSUE: begin
        stall = 1'b1;
        if (go) begin
          cp0_ena   = 1'b1;
          cause     = cause_q;
          state_nxt = ST_EXC_REDIR;
        end
      end
      ST_EXC_REDIR: begin
        if (go) begin
          pc_redirect = 1'b1;
          redirect_pc = EXC_VECTOR;
          state_nxt   = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      ST_ERET_ISSUE: begin
        stall = 1'b1;
        if (go) begin
          cp0_ena   = 1'b1;
          eret      = 1'b1;
          state_nxt = ST_ERET_REDIR;
        end
      end
      ST_ERET_REDIR: begin
        if (go) begin
          pc_redirect = 1'b1;
          redirect_pc = epc_q + ERET_OFFSET;
          state_nxt   = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign pc_out     = pc_q;
  assign nest_depth = depth_q;
  assign nest_err   = err_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: each step pushes the expected output
// snapshot to a queue, then pops and compares it against the DUT mid-cycle.
module tb_cp0_exc_ctrl;
  import cp0_pkg::*;

  logic        cp0_clk = 1'b0;
  logic        cp0_rst, ena;
  logic        is_syscall, is_break, is_teq, teq_equal;
  logic        is_mfc0, is_mtc0, is_eret;
  logic [4:0]  rd;
  logic [31:0] pc_in, epc_in;
  logic        cp0_ena, mfc0, mtc0, eret;
  logic [4:0]  cause;
  logic [31:0] addr, pc_out;
  logic        stall, pc_redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  nest_depth;
  logic        nest_err;
  logic [2:0]  dbg_state;

  typedef struct packed {
    logic        cp0_ena;
    logic        mfc0;
    logic        mtc0;
    logic        eret;
    logic [4:0]  cause;
    logic [31:0] addr;
    logic [31:0] pc_out;
    logic        stall;
    logic        pc_redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  nest_depth;
    logic        nest_err;
    logic [2:0]  st;
  } obs_t;

  localparam int W = $bits(obs_t);

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           checks = 0;
  int           failures = 0;
  logic [31:0]  m_pc;
  logic [2:0]   m_depth;
  logic         m_err;

  cp0_exc_ctrl dut (
    .cp0_clk     (cp0_clk),
    .cp0_rst     (cp0_rst),
    .ena         (ena),
    .is_syscall  (is_syscall),
    .is_break    (is_break),
    .is_teq      (is_teq),
    .teq_equal   (teq_equal),
    .is_mfc0     (is_mfc0),
    .is_mtc0     (is_mtc0),
    .is_eret     (is_eret),
    .rd          (rd),
    .pc_in       (pc_in),
    .epc_in      (epc_in),
    .cp0_ena     (cp0_ena),
    .mfc0        (mfc0),
    .mtc0        (mtc0),
    .eret        (eret),
    .cause       (cause),
    .addr        (addr),
    .pc_out      (pc_out),
    .stall       (stall),
    .pc_redirect (pc_redirect),
    .redirect_pc (redirect_pc),
    .nest_depth  (nest_depth),
    .nest_err    (nest_err),
    .dbg_state   (dbg_state)
  );

  // Clock / reset block
  always #5 cp0_clk = ~cp0_clk;

  function automatic obs_t quiet();
    obs_t e;
    e            = '0;
    e.pc_out     = m_pc;
    e.nest_depth = m_depth;
    e.nest_err   = m_err;
    e.st         = ST_IDLE;
    return e;
  endfunction

  task automatic idle_inputs();
    is_syscall = 1'b0;
    is_break   = 1'b0;
    is_teq     = 1'b0;
    teq_equal  = 1'b0;
    is_mfc0    = 1'b0;
    is_mtc0    = 1'b0;
    is_eret    = 1'b0;
    rd         = 5'd0;
  endtask

  // Called at posedge+1 with inputs driven; compares at posedge+4.
  task automatic cycle(input string tag, input obs_t e);
    obs_t         act;
    logic [W-1:0] exp_v;
    string        t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #3;
    act.cp0_ena     = cp0_ena;
    act.mfc0        = mfc0;
    act.mtc0        = mtc0;
    act.eret        = eret;
    act.cause       = cause;
    act.addr        = addr;
    act.pc_out      = pc_out;
    act.stall       = stall;
    act.pc_redirect = pc_redirect;
    act.redirect_pc = redirect_pc;
    act.nest_depth  = nest_depth;
    act.nest_err    = nest_err;
    act.st          = dbg_state;
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    checks++;
    assert (act === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, act, exp_v);
    end
    @(posedge cp0_clk);
    #1;
  endtask

  // Caller drives the trap flags; checks request, issue and redirect cycles.
  task automatic trap_seq(input string tag, input logic [31:0] pc, input logic [4:0] code);
    obs_t e;
    pc_in   = pc;
    e       = quiet();
    e.stall = 1'b1;
    cycle({tag, "_req"}, e);
    m_pc = pc;
    idle_inputs();
    e         = quiet();
    e.cp0_ena = 1'b1;
    e.cause   = code;
    e.stall   = 1'b1;
    e.st      = ST_EXC_ISSUE;
    cycle({tag, "_issue"}, e);
    m_depth = m_depth + 3'd1;
    e             = quiet();
    e.pc_redirect = 1'b1;
    e.redirect_pc = 32'h0040_0004;
    e.st          = ST_EXC_REDIR;
    cycle({tag, "_redir"}, e);
  endtask

  task automatic do_eret(input string tag, input logic [31:0] epc);
    obs_t e;
    is_eret = 1'b1;
    epc_in  = epc;
    e       = quiet();
    e.stall = 1'b1;
    cycle({tag, "_req"}, e);
    idle_inputs();
    e         = quiet();
    e.cp0_ena = 1'b1;
    e.eret    = 1'b1;
    e.stall   = 1'b1;
    e.st      = ST_ERET_ISSUE;
    cycle({tag, "_issue"}, e);
    m_depth = m_depth - 3'd1;
    e             = quiet();
    e.pc_redirect = 1'b1;
    e.redirect_pc = epc + 32'd4;
    e.st          = ST_ERET_REDIR;
    cycle({tag, "_redir"}, e);
  endtask

  initial begin
    obs_t e;
    cp0_rst = 1'b1;
    ena     = 1'b1;
    idle_inputs();
    pc_in   = '0;
    epc_in  = '0;
    m_pc    = '0;
    m_depth = '0;
    m_err   = 1'b0;
    // Decode flags held during reset must not reach CP0.
    is_mtc0 = 1'b1;
    rd      = 5'd14;
    #1;
    cycle("reset_0", quiet());
    cycle("reset_1", quiet());
    cp0_rst = 1'b0;
    idle_inputs();
    cycle("idle_after_reset", quiet());

    is_syscall = 1'b1;
    trap_seq("syscall", 32'h0040_0100, CAUSE_SYSCALL);
    do_eret("eret1", 32'h0040_0100);

    is_teq    = 1'b1;
    teq_equal = 1'b0;
    pc_in     = 32'h0040_0200;
    cycle("teq_untaken", quiet());
    idle_inputs();
    cycle("teq_untaken_after", quiet());
    is_teq    = 1'b1;
    teq_equal = 1'b1;
    trap_seq("teq", 32'h0040_0200, CAUSE_TEQ);
    do_eret("eret_teq", 32'h0040_0200);

    // Six nested BREAKs, some with lower-priority flags also raised.
    for (int i = 0; i < 6; i++) begin
      is_break  = 1'b1;
      is_teq    = i[0];
      teq_equal = 1'b1;
      is_mfc0   = i[1];
      rd        = 5'd13;
      trap_seq("brk", 32'h0040_1000 + 32'(i * 4), CAUSE_BREAK);
    end
    is_break = 1'b1;
    pc_in    = 32'h0040_2000;
    cycle("brk7_nop", quiet());
    idle_inputs();
    m_err = 1'b1;
    cycle("brk7_err", quiet());

    do_eret("unwind_wrap", 32'hFFFF_FFFC);
    for (int i = 0; i < 5; i++) begin
      do_eret("unwind", $urandom_range(32'h0000_0000, 32'h7FFF_FFFF));
    end
    is_eret = 1'b1;
    cycle("eret_depth0", quiet());
    idle_inputs();
    cycle("eret_depth0_after", quiet());

    is_mtc0    = 1'b1;
    rd         = REG_STATUS;
    is_syscall = 1'b1;
    trap_seq("sys_mtc0", 32'h0040_0300, CAUSE_SYSCALL);
    do_eret("eret_sys_mtc0", 32'h0040_0300);

    is_mtc0   = 1'b1;
    rd        = REG_EPC;
    e         = quiet();
    e.cp0_ena = 1'b1;
    e.mtc0    = 1'b1;
    e.addr    = 32'h0000_000E;
    cycle("mtc0_epc", e);
    idle_inputs();
    is_mfc0   = 1'b1;
    rd        = REG_CAUSE;
    e         = quiet();
    e.cp0_ena = 1'b1;
    e.mfc0    = 1'b1;
    e.addr    = 32'h0000_000D;
    cycle("mfc0_cause", e);
    idle_inputs();

    ena        = 1'b0;
    is_syscall = 1'b1;
    cycle("ena_off_idle", quiet());
    ena = 1'b1;
    idle_inputs();
    cycle("ena_on_idle", quiet());

    // Drop ena while the redirect is pending.
    is_syscall = 1'b1;
    pc_in      = 32'h0040_0400;
    e          = quiet();
    e.stall    = 1'b1;
    cycle("ena_drop_req", e);
    m_pc = 32'h0040_0400;
    idle_inputs();
    e         = quiet();
    e.cp0_ena = 1'b1;
    e.cause   = CAUSE_SYSCALL;
    e.stall   = 1'b1;
    e.st      = ST_EXC_ISSUE;
    cycle("ena_drop_issue", e);
    m_depth = m_depth + 3'd1;
    ena     = 1'b0;
    e       = quiet();
    e.stall = 1'b1;
    e.st    = ST_EXC_REDIR;
    cycle("ena_hold_0", e);
    cycle("ena_hold_1", e);
    ena           = 1'b1;
    e             = quiet();
    e.pc_redirect = 1'b1;
    e.redirect_pc = 32'h0040_0004;
    e.st          = ST_EXC_REDIR;
    cycle("ena_resume_redir", e);
    cycle("ena_resume_idle", quiet());

    // Reset mid-sequence at depth 1 with nest_err set.
    is_syscall = 1'b1;
    pc_in      = 32'h0040_0500;
    e          = quiet();
    e.stall    = 1'b1;
    cycle("rst_mid_req", e);
    idle_inputs();
    cp0_rst = 1'b1;
    m_pc    = '0;
    m_depth = '0;
    m_err   = 1'b0;
    cycle("rst_mid", quiet());
    cp0_rst = 1'b0;
    cycle("rst_no_redir", quiet());

    is_eret = 1'b1;
    epc_in  = 32'h0000_1234;
    cycle("eret0_after_rst", quiet());
    idle_inputs();
    m_err = 1'b1;
    cycle("eret0_err_set", quiet());
    cycle("eret0_err_sticky", quiet());

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
